// File: rtl/simple_comb_pkg.sv
// Shared constants for simple_comb_blk: the two hit codes and the minterm mask
// built from them, so the mask can never drift out of sync with the codes.
package simple_comb_pkg;

    localparam logic [2:0] CODE_HIT0 = 3'd1;
    localparam logic [2:0] CODE_HIT1 = 3'd4;

    // Evaluates to 8'b0001_0010.
    localparam logic [7:0] MINTERM_MASK = (8'b1 << CODE_HIT0) | (8'b1 << CODE_HIT1);

endpackage

// File: rtl/decoder_3to8.sv
// 3-bit binary code to 8-bit one-hot decode; purely combinational.
module decoder_3to8 (
    input  logic [2:0] code,
    output logic [7:0] onehot
);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dec
            assign onehot[gi] = (code == 3'(gi));
        end
    endgenerate

endmodule

// File: rtl/simple_comb_blk.sv
// Combinational hit decision on {a,b,c} plus registered copy, rising-edge pulse
// and saturating hit counter for downstream synchronous logic.
module simple_comb_blk
    import simple_comb_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               a,
    input  logic               b,
    input  logic               c,
    output logic               y,
    output logic [7:0]         minterm,
    output logic               y_q,
    output logic               y_rise,
    output logic [COUNT_W-1:0] hit_count
);

    logic               y_q_reg;
    logic               y_rise_reg;
    logic [COUNT_W-1:0] hit_count_reg;

    decoder_3to8 u_dec (
        .code   ({a, b, c}),
        .onehot (minterm)
    );

    // Reset deliberately does not touch this path.
    assign y = |(minterm & MINTERM_MASK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y_q_reg       <= 1'b0;
            y_rise_reg    <= 1'b0;
            hit_count_reg <= '0;
        end else begin
            y_q_reg    <= y;
            y_rise_reg <= y & ~y_q_reg;
            if (y && (hit_count_reg != {COUNT_W{1'b1}})) begin
                hit_count_reg <= hit_count_reg + COUNT_W'(1);
            end
        end
    end

    assign y_q       = y_q_reg;
    assign y_rise    = y_rise_reg;
    assign hit_count = hit_count_reg;

endmodule

// File: tb/tb_simple_comb_blk.sv
// Scoreboard bench for simple_comb_blk: an 8-bit and a 2-bit counter instance
// share stimulus; expectations are queued and checked on the falling edge.
module tb_simple_comb_blk;

    logic       clk = 1'b0;
    logic       reset;
    logic       a, b, c;
    logic       y8, y2, yq8, yq2, yr8, yr2;
    logic [7:0] mt8, mt2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        bit         regs;
        logic       y;
        logic [7:0] mt;
        logic       yq;
        logic       yr;
        logic [7:0] cnt;
        logic [1:0] cnt2;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    simple_comb_blk #(.COUNT_W(8)) u_dut8 (
        .clk(clk), .reset(reset), .a(a), .b(b), .c(c),
        .y(y8), .minterm(mt8), .y_q(yq8), .y_rise(yr8), .hit_count(cnt8)
    );

    simple_comb_blk #(.COUNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .a(a), .b(b), .c(c),
        .y(y2), .minterm(mt2), .y_q(yq2), .y_rise(yr2), .hit_count(cnt2)
    );

    task automatic cmp(input string nm, input string fld, input logic [7:0] act,
                       input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s: got %h want %h", nm, fld, act, req);
        end
    endtask

    // Monitor: outputs are presented each falling edge; pop one expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            cmp(e.name, "y8", {7'd0, y8}, {7'd0, e.y});
            cmp(e.name, "y2", {7'd0, y2}, {7'd0, e.y});
            cmp(e.name, "minterm", mt8, e.mt);
            if (e.regs) begin
                cmp(e.name, "y_q", {7'd0, yq8}, {7'd0, e.yq});
                cmp(e.name, "y_rise", {7'd0, yr8}, {7'd0, e.yr});
                cmp(e.name, "y_q_w2", {7'd0, yq2}, {7'd0, e.yq});
                cmp(e.name, "y_rise_w2", {7'd0, yr2}, {7'd0, e.yr});
                cmp(e.name, "hit_count", cnt8, e.cnt);
                cmp(e.name, "hit_count_w2", {6'd0, cnt2}, {6'd0, e.cnt2});
            end
            $display("check %s: abc=%b y=%b mt=%h yq=%b yr=%b cnt=%0d cnt2=%0d",
                     e.name, {a, b, c}, y8, mt8, yq8, yr8, cnt8, cnt2);
        end
    end

    function automatic exp_t mk(input string nm, input bit regs, input logic yv,
                                input logic [7:0] mt, input logic yq, input logic yr,
                                input logic [7:0] cn, input logic [1:0] cn2);
        exp_t e;
        e.name = nm; e.regs = regs; e.y = yv; e.mt = mt;
        e.yq = yq; e.yr = yr; e.cnt = cn; e.cnt2 = cn2;
        return e;
    endfunction

    // Drive a new code just after the rising edge.
    task automatic step(input logic [2:0] code);
        @(posedge clk);
        #1;
        {a, b, c} = code;
    endtask

    typedef struct {
        logic [2:0] code;
        bit         rst_on;
        bit         rst_off;
        logic       y;
        logic [7:0] mt;
        logic       yq;
        logic       yr;
        logic [7:0] cnt;
        logic [1:0] cnt2;
        string      name;
    } vec_t;

    // Hand-computed vectors; registered fields reflect the edge just before the check.
    vec_t seq[] = '{
        '{3'd0, 0, 0, 1'b0, 8'h01, 1'b0, 1'b0, 8'd0, 2'd0, "reset_hold"},
        '{3'd0, 0, 1, 1'b0, 8'h01, 1'b0, 1'b0, 8'd0, 2'd0, "reset_release"}
    };

    vec_t seq2[] = '{
        '{3'd0, 0, 0, 1'b0, 8'h01, 1'b0, 1'b0, 8'd2, 2'd2, "post_sweep"},
        '{3'd4, 1, 0, 1'b1, 8'h10, 1'b0, 1'b0, 8'd0, 2'd0, "async_reset"},
        '{3'd0, 0, 1, 1'b0, 8'h01, 1'b0, 1'b0, 8'd0, 2'd0, "ec0_a"},
        '{3'd0, 0, 0, 1'b0, 8'h01, 1'b0, 1'b0, 8'd0, 2'd0, "ec0_b"},
        '{3'd1, 0, 0, 1'b1, 8'h02, 1'b0, 1'b0, 8'd0, 2'd0, "ec1_a"},
        '{3'd1, 0, 0, 1'b1, 8'h02, 1'b1, 1'b1, 8'd1, 2'd1, "ec1_b"},
        '{3'd1, 0, 0, 1'b1, 8'h02, 1'b1, 1'b0, 8'd2, 2'd2, "ec1_c"},
        '{3'd0, 0, 0, 1'b0, 8'h01, 1'b1, 1'b0, 8'd3, 2'd3, "ec0_c"},
        '{3'd0, 0, 0, 1'b0, 8'h01, 1'b0, 1'b0, 8'd3, 2'd3, "ec0_d"},
        '{3'd0, 1, 0, 1'b0, 8'h01, 1'b0, 1'b0, 8'd0, 2'd0, "sat_prereset"},
        '{3'd4, 0, 1, 1'b1, 8'h10, 1'b0, 1'b0, 8'd0, 2'd0, "sat_h1"},
        '{3'd4, 0, 0, 1'b1, 8'h10, 1'b1, 1'b1, 8'd1, 2'd1, "sat_h2"},
        '{3'd4, 0, 0, 1'b1, 8'h10, 1'b1, 1'b0, 8'd2, 2'd2, "sat_h3"},
        '{3'd4, 0, 0, 1'b1, 8'h10, 1'b1, 1'b0, 8'd3, 2'd3, "sat_h4"},
        '{3'd4, 0, 0, 1'b1, 8'h10, 1'b1, 1'b0, 8'd4, 2'd3, "sat_h5"},
        '{3'd4, 0, 0, 1'b1, 8'h10, 1'b1, 1'b0, 8'd5, 2'd3, "sat_h6"},
        '{3'd0, 0, 0, 1'b0, 8'h01, 1'b1, 1'b0, 8'd6, 2'd3, "sat_end"},
        '{3'd0, 1, 0, 1'b0, 8'h01, 1'b0, 1'b0, 8'd0, 2'd0, "sat_reset"},
        '{3'd1, 0, 1, 1'b1, 8'h02, 1'b0, 1'b0, 8'd0, 2'd0, "recount_a"},
        '{3'd0, 0, 0, 1'b0, 8'h01, 1'b1, 1'b1, 8'd1, 2'd1, "recount_b"},
        '{3'd0, 0, 0, 1'b0, 8'h01, 1'b0, 1'b0, 8'd1, 2'd1, "recount_c"}
    };

    task automatic run_vec(input vec_t v);
        step(v.code);
        if (v.rst_off) reset = 1'b0;
        if (v.rst_on) begin
            #1;
            reset = 1'b1;
        end
        sb.push_back(mk(v.name, 1'b1, v.y, v.mt, v.yq, v.yr, v.cnt, v.cnt2));
    endtask

    initial begin
        reset = 1'b1;
        {a, b, c} = 3'd0;

        foreach (seq[i]) run_vec(seq[i]);

        // Exhaustive combinational sweep, each code held one 10-unit period.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] code;
            logic       yexp;
            logic [7:0] mexp;
            code = 3'(i);
            yexp = (i == 1) || (i == 4);
            mexp = 8'h01 << i;
            step(code);
            sb.push_back(mk($sformatf("sweep%0d", i), 1'b0, yexp, mexp,
                            1'b0, 1'b0, 8'd0, 2'd0));
        end

        foreach (seq2[i]) run_vec(seq2[i]);

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time=%0t limit=50000", $time);
        $fatal(1, "timeout");
    end

endmodule
